// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port, memory port and error flag shared by mem_arbiter.
// master is the arbiter's view; slave is the view of the clients and memory around it.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        err;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction-fetch and a data port,
// with a bounded wait for mem_ready and an err pulse on timed-out accesses.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic PortI = 1'b0;
  localparam logic PortD = 1'b1;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        pick;
  logic        finish;
  logic [31:0] cap;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    // Data wins when it is the only requester, or on a tie when fetch went last.
    pick      = bus.d_req & (~bus.i_req | (last_q == PortI));
    // A ready in the final allowed cycle still counts as success.
    finish    = bus.mem_ready | ((cnt_q + 8'd1) == TimeoutCnt);
    cap       = bus.mem_ready ? bus.mem_rdata : 32'h0;

    case (state_q)
      StIdle: begin
        if (bus.i_req || bus.d_req) begin
          state_d = StBusy;
          owner_d = pick;
          last_d  = pick;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          we_d    = pick & bus.d_we;
          addr_d  = pick ? bus.d_addr : bus.i_addr;
          wdata_d = pick ? bus.d_wdata : 32'h0;
        end
      end
      StBusy: begin
        if (finish) begin
          state_d = StResp;
          err_d   = ~bus.mem_ready;
          if (!we_q) begin
            if (owner_q == PortD) d_rdata_d = cap;
            else                  i_rdata_d = cap;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= PortI;
      last_q    <= PortD;
      cnt_q     <= 8'd0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.mem_req   = (state_q == StBusy);
  assign bus.mem_we    = we_q & (state_q == StBusy);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_ack     = (state_q == StResp) & (owner_q == PortI);
  assign bus.d_ack     = (state_q == StResp) & (owner_q == PortD);
  assign bus.err       = (state_q == StResp) & err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of grant order, latency, timeout and read data.
module tb_mem_arbiter;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = 32'h0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0;
    bus.d_wdata   = 32'h0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack, bus.err} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack, bus.err});
    else passes++;
    checks++;
    if ({bus.i_rdata, bus.d_rdata} !== 64'h0)
      $display("FAIL reset_rdata: got %h %h want 0 0", bus.i_rdata, bus.d_rdata);
    else passes++;
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== 64'h0)
      $display("FAIL reset_mem: got %h %h want 0 0", bus.mem_addr, bus.mem_wdata);
    else passes++;
  endtask

  task automatic test_fetch();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0040_0000;
    step();
    checks++;
    if ({bus.mem_req, bus.mem_we} !== 2'b10)
      $display("FAIL fetch_req_we: got %b want 10", {bus.mem_req, bus.mem_we});
    else passes++;
    checks++;
    if (bus.mem_addr !== 32'h0040_0000)
      $display("FAIL fetch_addr: got %h want 00400000", bus.mem_addr);
    else passes++;
    step();
    step();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h00A0_0093;
    checks++;
    if (bus.i_ack !== 1'b0) $display("FAIL fetch_early_ack: got %b want 0", bus.i_ack);
    else passes++;
    step();
    checks++;
    if ({bus.i_ack, bus.d_ack, bus.err, bus.mem_req} !== 4'b1000)
      $display("FAIL fetch_ack: got %b want 1000", {bus.i_ack, bus.d_ack, bus.err, bus.mem_req});
    else passes++;
    checks++;
    if (bus.i_rdata !== 32'h00A0_0093)
      $display("FAIL fetch_rdata: got %h want 00a00093", bus.i_rdata);
    else passes++;
    bus.mem_ready = 1'b0;
    bus.i_req     = 1'b0;
    step();
    checks++;
    if ({bus.i_ack, bus.i_rdata} !== {1'b0, 32'h00A0_0093})
      $display("FAIL fetch_after: got %b %h want 0 00a00093", bus.i_ack, bus.i_rdata);
    else passes++;
  endtask

  task automatic test_store();
    logic [31:0] prev;
    prev          = bus.d_rdata;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_addr    = 32'h1001_0000;
    bus.d_wdata   = 32'hDEAD_BEEF;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    step();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.d_ack} !== 3'b110)
      $display("FAIL store_busy: got %b want 110", {bus.mem_req, bus.mem_we, bus.d_ack});
    else passes++;
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== {32'h1001_0000, 32'hDEAD_BEEF})
      $display("FAIL store_bus: got %h %h want 10010000 deadbeef", bus.mem_addr, bus.mem_wdata);
    else passes++;
    step();
    checks++;
    if ({bus.d_ack, bus.i_ack, bus.err, bus.mem_req, bus.mem_we} !== 5'b10000)
      $display("FAIL store_ack: got %b want 10000",
               {bus.d_ack, bus.i_ack, bus.err, bus.mem_req, bus.mem_we});
    else passes++;
    checks++;
    if (bus.d_rdata !== prev) $display("FAIL store_rdata: got %h want %h", bus.d_rdata, prev);
    else passes++;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.mem_ready = 1'b0;
    step();
    checks++;
    if ({bus.d_ack, bus.mem_we} !== 2'b00)
      $display("FAIL store_after: got %b want 00", {bus.d_ack, bus.mem_we});
    else passes++;
  endtask

  task automatic test_round_robin();
    logic order[$];
    int   both;
    logic got;
    both = 0;
    idle_inputs();
    do_reset();
    bus.i_req     = 1'b1;
    bus.i_addr    = 32'h0000_1000;
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h2000_0000;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 14; c++) begin
      step();
      if (bus.i_ack && bus.d_ack) both++;
      if (bus.i_ack) order.push_back(1'b0);
      if (bus.d_ack) order.push_back(1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      got = (k < order.size()) ? order[k] : 1'bx;
      checks++;
      if (got !== k[0]) $display("FAIL rr_order%0d: got port %b want %b", k, got, k[0]);
      else passes++;
    end
    checks++;
    if (both !== 0) $display("FAIL rr_dual_ack: got %0d want 0", both);
    else passes++;
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_timeout();
    int          busy;
    int          guard;
    logic        seen;
    logic [2:0]  flags;
    logic [31:0] rd;
    busy          = 0;
    guard         = 0;
    seen          = 1'b0;
    flags         = 3'b0;
    rd            = 32'hx;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h2000_0040;
    bus.mem_ready = 1'b0;
    while (!seen && guard < 40) begin
      step();
      guard++;
      if (bus.mem_req) busy++;
      if (bus.d_ack || bus.i_ack) begin
        seen  = 1'b1;
        flags = {bus.d_ack, bus.i_ack, bus.err};
        rd    = bus.d_rdata;
      end
    end
    checks++;
    if (!seen) $display("FAIL to_no_ack: got none within %0d cycles want ack", guard);
    else passes++;
    checks++;
    if (busy !== TIMEOUT) $display("FAIL to_busy_len: got %0d want %0d", busy, TIMEOUT);
    else passes++;
    checks++;
    if (flags !== 3'b101) $display("FAIL to_flags: got %b want 101", flags);
    else passes++;
    checks++;
    if (rd !== 32'h0) $display("FAIL to_rdata: got %h want 0", rd);
    else passes++;
    bus.d_req = 1'b0;
    step();
    checks++;
    if (bus.err !== 1'b0) $display("FAIL to_err_pulse: got %b want 0", bus.err);
    else passes++;
  endtask

  task automatic test_reset_busy();
    int   guard;
    logic seen;
    logic [1:0] acks;
    guard         = 0;
    seen          = 1'b0;
    acks          = 2'b0;
    bus.i_req     = 1'b1;
    bus.i_addr    = 32'h0040_0100;
    bus.mem_ready = 1'b0;
    step();
    step();
    rst       = 1'b1;
    bus.i_req = 1'b0;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.mem_req, bus.i_ack, bus.d_ack} !== 3'b000)
      $display("FAIL rb_abort: got %b want 000", {bus.mem_req, bus.i_ack, bus.d_ack});
    else passes++;
    checks++;
    if (bus.i_rdata !== 32'h0) $display("FAIL rb_rdata: got %h want 0", bus.i_rdata);
    else passes++;
    step();
    checks++;
    if ({bus.mem_req, bus.i_ack} !== 2'b00)
      $display("FAIL rb_no_late_ack: got %b want 00", {bus.mem_req, bus.i_ack});
    else passes++;
    bus.i_req     = 1'b1;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.mem_ready = 1'b1;
    while (!seen && guard < 10) begin
      step();
      guard++;
      if (bus.i_ack || bus.d_ack) begin
        seen = 1'b1;
        acks = {bus.i_ack, bus.d_ack};
      end
    end
    checks++;
    if (acks !== 2'b10) $display("FAIL rb_tie_grant: got %b want 10 (i_ack,d_ack)", acks);
    else passes++;
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_random(input int n);
    logic        last_m;
    logic        exp_port;
    logic        exp_we;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    logic [31:0] rd;
    logic [2:0]  flags;
    int          lat;
    int          exp_busy;
    int          busy;
    int          guard;
    logic        seen;
    idle_inputs();
    do_reset();
    last_m = 1'b1;
    exp_i  = 32'h0;
    exp_d  = 32'h0;
    for (int t = 0; t < n; t++) begin
      if (!bus.i_req && $urandom_range(0, 2) != 0) begin
        bus.i_req  = 1'b1;
        bus.i_addr = $urandom;
      end
      if (!bus.d_req && $urandom_range(0, 2) != 0) begin
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
      if (!bus.i_req && !bus.d_req) begin
        bus.i_req  = 1'b1;
        bus.i_addr = $urandom;
      end
      exp_port  = (bus.i_req && bus.d_req) ? ~last_m : bus.d_req;
      last_m    = exp_port;
      exp_addr  = exp_port ? bus.d_addr : bus.i_addr;
      exp_we    = exp_port & bus.d_we;
      exp_wdata = bus.d_wdata;
      lat       = $urandom_range(0, TIMEOUT + 2);
      rd        = $urandom;
      exp_err   = (lat >= TIMEOUT);
      exp_busy  = exp_err ? TIMEOUT : lat + 1;
      step();
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, exp_we, exp_addr})
        $display("FAIL rnd_grant t%0d: got %b %b %h want 1 %b %h", t,
                 bus.mem_req, bus.mem_we, bus.mem_addr, exp_we, exp_addr);
      else passes++;
      if (exp_we) begin
        checks++;
        if (bus.mem_wdata !== exp_wdata)
          $display("FAIL rnd_wdata t%0d: got %h want %h", t, bus.mem_wdata, exp_wdata);
        else passes++;
      end
      // Occasionally withdraw the request mid-access; the ack must still arrive.
      if ($urandom_range(0, 7) == 0) begin
        if (exp_port) bus.d_req = 1'b0;
        else          bus.i_req = 1'b0;
      end
      busy  = 0;
      guard = 0;
      seen  = 1'b0;
      flags = 3'b0;
      while (!seen && guard < int'(TIMEOUT) + 8) begin
        bus.mem_ready = (busy == lat);
        bus.mem_rdata = (busy == lat) ? rd : $urandom;
        if (bus.mem_req) busy++;
        step();
        guard++;
        if (bus.i_ack || bus.d_ack) begin
          seen  = 1'b1;
          flags = {bus.i_ack, bus.d_ack, bus.err};
        end
      end
      if (!exp_we) begin
        if (exp_port) exp_d = exp_err ? 32'h0 : rd;
        else          exp_i = exp_err ? 32'h0 : rd;
      end
      checks++;
      if (!seen) $display("FAIL rnd_no_ack t%0d: got none within %0d cycles want ack", t, guard);
      else passes++;
      checks++;
      if (busy !== exp_busy) $display("FAIL rnd_busy t%0d: got %0d want %0d", t, busy, exp_busy);
      else passes++;
      checks++;
      if (flags !== {~exp_port, exp_port, exp_err})
        $display("FAIL rnd_ack t%0d: got %b want %b", t, flags, {~exp_port, exp_port, exp_err});
      else passes++;
      checks++;
      if ({bus.i_rdata, bus.d_rdata} !== {exp_i, exp_d})
        $display("FAIL rnd_rdata t%0d: got %h %h want %h %h", t,
                 bus.i_rdata, bus.d_rdata, exp_i, exp_d);
      else passes++;
      if (exp_port) bus.d_req = 1'b0;
      else          bus.i_req = 1'b0;
      bus.mem_ready = 1'($urandom_range(0, 1));
      step();
      bus.mem_ready = 1'($urandom_range(0, 1));
    end
    idle_inputs();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_store();
    test_round_robin();
    test_timeout();
    test_reset_busy();
    test_random(40);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
